// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle IF/ID/EXE/MEM/WB control unit driving ALUctr and datapath enables.
// Optional build macro OVF_TRAP_EN: signed add/sub overflow in WB enters a sticky TRAP state.
module multicycle_ctrl_fsm #(
    parameter int           MEM_LAT  = 1,
    parameter logic [5:0]   OP_RTYPE = 6'h00,
    parameter logic [5:0]   OP_ORI   = 6'h0d,
    parameter logic [5:0]   OP_LW    = 6'h23,
    parameter logic [5:0]   OP_SW    = 6'h2b,
    parameter logic [5:0]   OP_BEQ   = 6'h04,
    parameter logic [5:0]   OP_J     = 6'h02
) (
    input  logic        CU_clk,
    input  logic        CU_rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        overflow,
    output logic [2:0]  ALUctr,
    output logic        ALUSrcB,
    output logic        ExtOp,
    output logic        PCWr,
    output logic        PCWrCond,
    output logic [1:0]  PCSrc,
    output logic        IRWr,
    output logic        MemRd,
    output logic        MemWr,
    output logic        RegWr,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        illegal,
    output logic [3:0]  state
);

    localparam logic [3:0] ST_IF   = 4'd0;
    localparam logic [3:0] ST_ID   = 4'd1;
    localparam logic [3:0] ST_EXE  = 4'd2;
    localparam logic [3:0] ST_BR   = 4'd3;
    localparam logic [3:0] ST_WB   = 4'd4;
    localparam logic [3:0] ST_MEM  = 4'd5;
    localparam logic [3:0] ST_LWB  = 4'd6;
    localparam logic [3:0] ST_TRAP = 4'd7;
    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    // Returns {supported, ALUctr} for an R-type funct field.
    function automatic logic [3:0] rtype_decode(input logic [5:0] f);
        case (f)
            6'h21:   rtype_decode = 4'b1_000;
            6'h20:   rtype_decode = 4'b1_001;
            6'h25:   rtype_decode = 4'b1_010;
            6'h23:   rtype_decode = 4'b1_100;
            6'h22:   rtype_decode = 4'b1_101;
            6'h2b:   rtype_decode = 4'b1_110;
            6'h2a:   rtype_decode = 4'b1_111;
            default: rtype_decode = 4'b0_000;
        endcase
    endfunction

    logic [3:0] state_r, state_next_s;
    logic [3:0] cnt_r, cnt_next_s;
    logic       cnt_last_s;
    logic       is_r_s, is_ori_s, is_lw_s, is_sw_s, is_beq_s, is_j_s, legal_s;
    logic [3:0] rdec_s;
    logic [2:0] alu_sel_s;
    logic       unused_s;

    assign is_r_s     = (op == OP_RTYPE);
    assign is_ori_s   = (op == OP_ORI);
    assign is_lw_s    = (op == OP_LW);
    assign is_sw_s    = (op == OP_SW);
    assign is_beq_s   = (op == OP_BEQ);
    assign is_j_s     = (op == OP_J);
    assign rdec_s     = rtype_decode(funct);
    assign legal_s    = (is_r_s & rdec_s[3]) | is_ori_s | is_lw_s | is_sw_s | is_beq_s;
    assign cnt_last_s = (cnt_r == LAST_CNT);
    // zero qualifies PCWrCond inside the datapath, not here.
    assign unused_s   = zero ^ overflow;

`ifdef OVF_TRAP_EN
    logic ovf_trap_s;
    assign ovf_trap_s = is_r_s & ((funct == 6'h20) | (funct == 6'h22)) & overflow;
`endif

    // ALU operation selected by the held IR fields.
    always_comb begin
        alu_sel_s = 3'b000;
        if (is_r_s) begin
            alu_sel_s = rdec_s[2:0];
        end else if (is_ori_s) begin
            alu_sel_s = 3'b010;
        end else if (is_beq_s) begin
            alu_sel_s = 3'b101;
        end else begin
            alu_sel_s = 3'b000;
        end
    end

    // State and wait-counter register.
    always_ff @(posedge CU_clk) begin
        if (CU_rst) begin
            state_r <= ST_IF;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state and counter logic; the counter only runs while IF/MEM wait on memory.
    always_comb begin
        state_next_s = ST_IF;
        cnt_next_s   = 4'd0;
        case (state_r)
`ifdef OVF_TRAP_EN
            ST_IF: begin
`else
            ST_IF, ST_TRAP: begin
`endif
                if (cnt_last_s) begin
                    state_next_s = ST_ID;
                end else begin
                    state_next_s = ST_IF;
                    cnt_next_s   = cnt_r + 4'd1;
                end
            end
            ST_ID: begin
                if (is_j_s) begin
                    state_next_s = ST_IF;
                end else if (legal_s) begin
                    state_next_s = ST_EXE;
                end else begin
                    state_next_s = ST_IF;
                end
            end
            ST_EXE: begin
                if (is_beq_s) begin
                    state_next_s = ST_BR;
                end else if (is_lw_s | is_sw_s) begin
                    state_next_s = ST_MEM;
                end else begin
                    state_next_s = ST_WB;
                end
            end
            ST_WB: begin
`ifdef OVF_TRAP_EN
                if (ovf_trap_s) begin
                    state_next_s = ST_TRAP;
                end else begin
                    state_next_s = ST_IF;
                end
`else
                state_next_s = ST_IF;
`endif
            end
            ST_MEM: begin
                if (!cnt_last_s) begin
                    state_next_s = ST_MEM;
                    cnt_next_s   = cnt_r + 4'd1;
                end else if (is_lw_s) begin
                    state_next_s = ST_LWB;
                end else begin
                    state_next_s = ST_IF;
                end
            end
`ifdef OVF_TRAP_EN
            ST_TRAP: state_next_s = ST_TRAP;
`endif
            default: state_next_s = ST_IF;
        endcase
    end

    // Moore output decode; everything is forced low while reset is asserted.
    always_comb begin
        ALUctr   = 3'b000;
        ALUSrcB  = 1'b0;
        ExtOp    = 1'b0;
        PCWr     = 1'b0;
        PCWrCond = 1'b0;
        PCSrc    = 2'b00;
        IRWr     = 1'b0;
        MemRd    = 1'b0;
        MemWr    = 1'b0;
        RegWr    = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        illegal  = 1'b0;
        state    = 4'd0;
        if (CU_rst) begin
            state = 4'd0;
        end else begin
            state = state_r;
            case (state_r)
`ifdef OVF_TRAP_EN
                ST_IF: begin
`else
                ST_IF, ST_TRAP: begin
`endif
                    MemRd = 1'b1;
                    IRWr  = cnt_last_s;
                    PCWr  = cnt_last_s;
                end
                ST_ID: begin
                    PCWr    = is_j_s;
                    PCSrc   = is_j_s ? 2'b10 : 2'b00;
                    illegal = ~is_j_s & ~legal_s;
                end
                ST_EXE: begin
                    ALUctr  = alu_sel_s;
                    ALUSrcB = is_ori_s | is_lw_s | is_sw_s;
                    ExtOp   = is_lw_s | is_sw_s;
                end
                ST_BR: begin
                    ALUctr   = alu_sel_s;
                    PCWrCond = 1'b1;
                    PCSrc    = 2'b01;
                end
                ST_WB: begin
                    ALUctr = alu_sel_s;
                    RegDst = is_r_s;
`ifdef OVF_TRAP_EN
                    RegWr  = ~ovf_trap_s;
`else
                    RegWr  = 1'b1;
`endif
                end
                ST_MEM: begin
                    ALUctr = alu_sel_s;
                    MemRd  = is_lw_s;
                    MemWr  = is_sw_s;
                end
                ST_LWB: begin
                    ALUctr   = alu_sel_s;
                    RegWr    = 1'b1;
                    MemtoReg = 1'b1;
                end
                default: ALUctr = 3'b000;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm at MEM_LAT=1 and MEM_LAT=3 (honours OVF_TRAP_EN).
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] aluctr;
        logic       alusrcb;
        logic       extop;
        logic       pcwr;
        logic       pcwrcond;
        logic [1:0] pcsrc;
        logic       irwr;
        logic       memrd;
        logic       memwr;
        logic       regwr;
        logic       regdst;
        logic       memtoreg;
        logic       illegal;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst1 = 1'b1;
    logic       rst3 = 1'b1;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h21;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;
    int         sel_lat = 1;
    int         errors = 0;
    int         checks = 0;
    exp_t       sb[$];

    logic [2:0] a1_aluctr, a3_aluctr;
    logic       a1_alusrcb, a1_extop, a1_pcwr, a1_pcwrcond, a1_irwr, a1_memrd, a1_memwr;
    logic       a1_regwr, a1_regdst, a1_memtoreg, a1_illegal;
    logic       a3_alusrcb, a3_extop, a3_pcwr, a3_pcwrcond, a3_irwr, a3_memrd, a3_memwr;
    logic       a3_regwr, a3_regdst, a3_memtoreg, a3_illegal;
    logic [1:0] a1_pcsrc, a3_pcsrc;
    logic [3:0] a1_state, a3_state;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.MEM_LAT(1)) dut1 (
        .CU_clk(clk), .CU_rst(rst1), .op(op), .funct(funct), .zero(zero), .overflow(overflow),
        .ALUctr(a1_aluctr), .ALUSrcB(a1_alusrcb), .ExtOp(a1_extop), .PCWr(a1_pcwr),
        .PCWrCond(a1_pcwrcond), .PCSrc(a1_pcsrc), .IRWr(a1_irwr), .MemRd(a1_memrd),
        .MemWr(a1_memwr), .RegWr(a1_regwr), .RegDst(a1_regdst), .MemtoReg(a1_memtoreg),
        .illegal(a1_illegal), .state(a1_state)
    );

    multicycle_ctrl_fsm #(.MEM_LAT(3)) dut3 (
        .CU_clk(clk), .CU_rst(rst3), .op(op), .funct(funct), .zero(zero), .overflow(overflow),
        .ALUctr(a3_aluctr), .ALUSrcB(a3_alusrcb), .ExtOp(a3_extop), .PCWr(a3_pcwr),
        .PCWrCond(a3_pcwrcond), .PCSrc(a3_pcsrc), .IRWr(a3_irwr), .MemRd(a3_memrd),
        .MemWr(a3_memwr), .RegWr(a3_regwr), .RegDst(a3_regdst), .MemtoReg(a3_memtoreg),
        .illegal(a3_illegal), .state(a3_state)
    );

    function automatic exp_t sample();
        exp_t o;
        if (sel_lat == 1) begin
            o = '{a1_state, a1_aluctr, a1_alusrcb, a1_extop, a1_pcwr, a1_pcwrcond, a1_pcsrc,
                  a1_irwr, a1_memrd, a1_memwr, a1_regwr, a1_regdst, a1_memtoreg, a1_illegal};
        end else begin
            o = '{a3_state, a3_aluctr, a3_alusrcb, a3_extop, a3_pcwr, a3_pcwrcond, a3_pcsrc,
                  a3_irwr, a3_memrd, a3_memwr, a3_regwr, a3_regdst, a3_memtoreg, a3_illegal};
        end
        return o;
    endfunction

    task automatic check(input string tag, input exp_t e);
        exp_t o;
        o = sample();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Reference model: expected per-cycle output vector for one instruction.
    task automatic push_instr(input logic [5:0] o, input logic [5:0] f, input logic ovf, input int lat);
        exp_t e;
        logic [2:0] a;
        bit ok, is_r, is_lw, is_sw;
        is_r  = (o == 6'h00);
        is_lw = (o == 6'h23);
        is_sw = (o == 6'h2b);
        ok = 1'b1;
        a  = 3'b000;
        if (is_r) begin
            case (f)
                6'h21: a = 3'b000;
                6'h20: a = 3'b001;
                6'h25: a = 3'b010;
                6'h23: a = 3'b100;
                6'h22: a = 3'b101;
                6'h2b: a = 3'b110;
                6'h2a: a = 3'b111;
                default: ok = 1'b0;
            endcase
        end else if (o == 6'h0d) a = 3'b010;
        else if (o == 6'h04) a = 3'b101;
        else if (!(is_lw || is_sw || o == 6'h02)) ok = 1'b0;
        for (int i = 0; i < lat; i++) begin
            e = '0; e.memrd = 1'b1;
            if (i == lat - 1) begin e.irwr = 1'b1; e.pcwr = 1'b1; end
            sb.push_back(e);
        end
        e = '0; e.st = 4'd1;
        if (o == 6'h02) begin
            e.pcwr = 1'b1; e.pcsrc = 2'b10; sb.push_back(e); return;
        end
        if (!ok) begin
            e.illegal = 1'b1; sb.push_back(e); return;
        end
        sb.push_back(e);
        e = '0; e.st = 4'd2; e.aluctr = a;
        e.alusrcb = (o == 6'h0d) || is_lw || is_sw;
        e.extop = is_lw || is_sw;
        sb.push_back(e);
        if (o == 6'h04) begin
            e = '0; e.st = 4'd3; e.aluctr = a; e.pcwrcond = 1'b1; e.pcsrc = 2'b01;
            sb.push_back(e);
        end else if (is_lw || is_sw) begin
            for (int i = 0; i < lat; i++) begin
                e = '0; e.st = 4'd5; e.aluctr = a; e.memrd = is_lw; e.memwr = is_sw;
                sb.push_back(e);
            end
            if (is_lw) begin
                e = '0; e.st = 4'd6; e.aluctr = a; e.regwr = 1'b1; e.memtoreg = 1'b1;
                sb.push_back(e);
            end
        end else begin
            e = '0; e.st = 4'd4; e.aluctr = a; e.regwr = 1'b1; e.regdst = is_r;
`ifdef OVF_TRAP_EN
            if (is_r && (f == 6'h20 || f == 6'h22) && ovf) begin
                e.regwr = 1'b0; sb.push_back(e);
                e = '0; e.st = 4'd7;
                repeat (3) sb.push_back(e);
                return;
            end
`endif
            sb.push_back(e);
        end
    endtask

    // Entered and left at posedge+1; limit>0 truncates the instruction (abort test).
    task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic ovf, input int limit);
        exp_t e;
        int n;
        op = o; funct = f; zero = z; overflow = ovf;
        push_instr(o, f, ovf, sel_lat);
        n = 0;
        while (sb.size() > 0) begin
            if (limit > 0 && n >= limit) begin
                sb.delete();
                break;
            end
            @(negedge clk);
            e = sb.pop_front();
            check(tag, e);
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        if (sel_lat == 1) rst1 = 1'b1; else rst3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(tag, exp_t'(0));
        @(posedge clk);
        #1;
        if (sel_lat == 1) rst1 = 1'b0; else rst3 = 1'b0;
    endtask

    initial begin
        sel_lat = 1;
        do_reset("reset1");
        run("addu", 6'h00, 6'h21, 1'b0, 1'b0, 0);
        run("beq_taken", 6'h04, 6'h00, 1'b1, 1'b0, 0);
        run("beq_not_taken", 6'h04, 6'h00, 1'b0, 1'b0, 0);
        run("ori", 6'h0d, 6'h3f, 1'b0, 1'b0, 0);
        run("lw", 6'h23, 6'h00, 1'b0, 1'b0, 0);
        run("sw", 6'h2b, 6'h00, 1'b0, 1'b0, 0);
        run("j", 6'h02, 6'h00, 1'b0, 1'b0, 0);
        run("illegal_op", 6'h3f, 6'h21, 1'b0, 1'b0, 0);
        run("illegal_funct", 6'h00, 6'h3f, 1'b0, 1'b0, 0);
        run("add", 6'h00, 6'h20, 1'b0, 1'b0, 0);
        run("or", 6'h00, 6'h25, 1'b0, 1'b0, 0);
        run("subu", 6'h00, 6'h23, 1'b0, 1'b0, 0);
        run("sub", 6'h00, 6'h22, 1'b0, 1'b0, 0);
        run("sltu", 6'h00, 6'h2b, 1'b0, 1'b0, 0);
        run("slt", 6'h00, 6'h2a, 1'b0, 1'b0, 0);
        run("addu_ovf_ignored", 6'h00, 6'h21, 1'b0, 1'b1, 0);
        run("lw_abort", 6'h23, 6'h00, 1'b0, 1'b0, 3);
        do_reset("reset_mid_instr");
        run("addu_after_abort", 6'h00, 6'h21, 1'b0, 1'b0, 0);
        run("add_ovf", 6'h00, 6'h20, 1'b0, 1'b1, 0);
        do_reset("reset_after_ovf");
        run("sub_after_ovf", 6'h00, 6'h22, 1'b0, 1'b0, 0);
        rst1 = 1'b1;
        sel_lat = 3;
        do_reset("reset3");
        run("lw_lat3", 6'h23, 6'h00, 1'b0, 1'b0, 0);
        run("sw_lat3", 6'h2b, 6'h00, 1'b0, 1'b0, 0);
        run("addu_lat3", 6'h00, 6'h21, 1'b0, 1'b0, 0);
        run("j_lat3", 6'h02, 6'h00, 1'b0, 1'b0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
